// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive deserializer.
// Holds the FSM state type and the constants derived from the bit timing parameters.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_LOAD,
      S_ERR
   } rx_state_t;

   localparam int DEF_NUMBITS      = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

   // cyc value at which the start bit is checked (mid bit)
   function automatic int half_last(input int cpb);
      return cpb / 2 - 1;
   endfunction

   // cyc value at which a data or stop bit is sampled
   function automatic int bit_last(input int cpb);
      return cpb - 1;
   endfunction

   function automatic int cyc_w(input int cpb);
      return $clog2(cpb);
   endfunction

   function automatic int idx_w(input int nb);
      return $clog2(nb + 1);
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial-in / parallel-out bundle of the UART receive deserializer.
// master: deserializer side (serial_in in; p_data, load_enable, framing_error, busy out).
interface uart_rx_deserializer_if
   import uart_rx_pkg::*;
#(
   parameter int NUMBITS = DEF_NUMBITS
);

   logic               serial_in;
   logic [NUMBITS-1:0] p_data;
   logic               load_enable;
   logic               framing_error;
   logic               busy;

   modport master (
      input  serial_in,
      output p_data,
      output load_enable,
      output framing_error,
      output busy
   );

   modport slave (
      output serial_in,
      input  p_data,
      input  load_enable,
      input  framing_error,
      input  busy
   );

endinterface

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the async serial line plus falling-edge detector.
// Ports: clk, n_rst, i_serial (async line), o_sync (synced line), o_start_edge (1->0).
module rx_sync_edge (
   input  logic clk,
   input  logic n_rst,
   input  logic i_serial,
   output logic o_sync,
   output logic o_start_edge
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Reset to the idle (high) level so reset release never fakes a start edge
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_serial;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync       = r_sync;
   assign o_start_edge = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: LSB-first framed serial to NUMBITS parallel word with load strobe.
// Ports: clk, n_rst, rx (master: serial_in in; p_data, load_enable, framing_error, busy out).
module uart_rx_deserializer
   import uart_rx_pkg::*;
#(
   parameter int NUMBITS      = DEF_NUMBITS,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  n_rst,
   uart_rx_deserializer_if.master rx
);

   localparam int CW = cyc_w(CLKS_PER_BIT);
   localparam int BW = idx_w(NUMBITS);

   localparam logic [CW-1:0] HALF_LAST = CW'(half_last(CLKS_PER_BIT));
   localparam logic [CW-1:0] FULL_LAST = CW'(bit_last(CLKS_PER_BIT));
   localparam logic [BW-1:0] IDX_LAST  = BW'(NUMBITS - 1);

   rx_state_t          r_state;
   rx_state_t          w_next;
   logic [CW-1:0]      r_cyc;
   logic [BW-1:0]      r_bit_idx;
   logic [NUMBITS-1:0] r_shift;
   logic [NUMBITS-1:0] w_shift_in;
   logic               r_pend;
   logic               w_sync;
   logic               w_start_edge;
   logic               w_half;
   logic               w_full;
   logic               w_shift_en;
   logic               w_cyc_clr;
   logic               w_counting;

   rx_sync_edge u_sync (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_serial     (rx.serial_in),
      .o_sync       (w_sync),
      .o_start_edge (w_start_edge)
   );

   assign w_half     = (r_cyc == HALF_LAST);
   assign w_full     = (r_cyc == FULL_LAST);
   assign w_counting = (r_state == S_START) ||
                       (r_state == S_DATA) ||
                       (r_state == S_STOP);

   // New bit enters at the MSB so the first (LSB) bit ends up in bit 0
   generate
      if (NUMBITS > 1) begin : g_wide
         assign w_shift_in = {w_sync, r_shift[NUMBITS-1:1]};
      end else begin : g_one
         assign w_shift_in = w_sync;
      end
   endgenerate

   always_comb begin
      w_next     = r_state;
      w_shift_en = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start_edge || r_pend)
               w_next = S_START;
         end
         S_START: begin
            if (w_half)
               w_next = w_sync ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_full) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == IDX_LAST)
                  w_next = S_STOP;
            end
         end
         S_STOP: begin
            if (w_full)
               w_next = w_sync ? S_LOAD : S_ERR;
         end
         S_LOAD:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // cyc restarts on every state entry and after each data sample
      w_cyc_clr = (w_next != r_state) || w_shift_en;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_cyc <= '0;
      else if (w_cyc_clr)
         r_cyc <= '0;
      else if (w_counting)
         r_cyc <= r_cyc + CW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_bit_idx <= '0;
      else if (r_state == S_START)
         r_bit_idx <= '0;
      else if (w_shift_en)
         r_bit_idx <= r_bit_idx + BW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_shift <= '0;
      else if (w_shift_en)
         r_shift <= w_shift_in;
   end

   // A start edge seen during the one-cycle LOAD/ERR is replayed in IDLE
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         r_pend <= 1'b0;
      else if (r_state == S_LOAD || r_state == S_ERR)
         r_pend <= w_start_edge;
      else
         r_pend <= 1'b0;
   end

   assign rx.p_data        = r_shift;
   assign rx.load_enable   = (r_state == S_LOAD);
   assign rx.framing_error = (r_state == S_ERR);
   assign rx.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized self-checking bench for uart_rx_deserializer.
// Frames are driven bit by bit; a queue model predicts the strobes.
module tb_uart_rx_deserializer;

   localparam int NB  = 8;
   localparam int CPB = 4;
   localparam int LAT = 2 + 1 + CPB / 2 + (NB + 1) * CPB + 1;

   typedef struct {
      bit            err;
      logic [NB-1:0] data;
      int            t;
   } ev_t;

   logic clk = 1'b0;
   logic n_rst;

   uart_rx_deserializer_if #(.NUMBITS(NB)) rx();

   uart_rx_deserializer #(
      .NUMBITS      (NB),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .rx    (rx)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   cyc_cnt = 0;
   int   t_start = 0;
   int   wide_cnt = 0;
   int   busy_after = 0;
   int   busy_cycles = 0;
   logic prev_le = 1'b0;
   logic prev_fe = 1'b0;
   ev_t  ev_q[$];
   ev_t  exp_q[$];

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      if (rx.load_enable || rx.framing_error) begin
         ev_t e;
         e.err  = rx.framing_error;
         e.data = rx.p_data;
         e.t    = cyc_cnt;
         ev_q.push_back(e);
      end
      if ((rx.load_enable && prev_le) || (rx.framing_error && prev_fe))
         wide_cnt++;
      if ((prev_le || prev_fe) && rx.busy)
         busy_after++;
      if (rx.busy)
         busy_cycles++;
      prev_le = rx.load_enable;
      prev_fe = rx.framing_error;
   end

   task automatic clear_log();
      ev_q.delete();
      exp_q.delete();
      wide_cnt    = 0;
      busy_after  = 0;
      busy_cycles = 0;
   endtask

   task automatic hold(input logic b, input int n);
      @(negedge clk);
      rx.serial_in = b;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [NB-1:0] d, input logic stop,
                             input int gap);
      ev_t e;
      @(negedge clk);
      rx.serial_in = 1'b0;
      t_start = cyc_cnt;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < NB; i++) hold(d[i], CPB);
      hold(stop, CPB);
      if (gap > 0) hold(1'b1, gap);
      e.err  = !stop;
      e.data = d;
      e.t    = 0;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      rx.serial_in = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (rx.load_enable !== 1'b0)
         $display("FAIL reset_le: got %b want 0", rx.load_enable);
      if (rx.load_enable !== 1'b0) bad++;
      total++;
      if (rx.framing_error !== 1'b0) begin
         bad++;
         $display("FAIL reset_fe: got %b want 0", rx.framing_error);
      end
      total++;
      if (rx.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy: got %b want 0", rx.busy);
      end
      total++;
      if (rx.p_data !== '0) begin
         bad++;
         $display("FAIL reset_pdata: got %h want 00", rx.p_data);
      end
      @(negedge clk);
      n_rst = 1'b1;
      clear_log();
      repeat (2 * CPB) @(negedge clk);
      total++;
      if (ev_q.size() !== 0 || rx.busy !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: events %0d busy %b want 0 0",
                  ev_q.size(), rx.busy);
      end
   endtask

   task automatic test_single();
      int lat;
      clear_log();
      send_frame(8'hA5, 1'b1, 0);
      settle();
      total++;
      if (ev_q.size() !== 1) begin
         bad++;
         $display("FAIL single_count: got %0d want 1", ev_q.size());
      end
      if (ev_q.size() > 0) begin
         total++;
         if (ev_q[0].err !== 1'b0) begin
            bad++;
            $display("FAIL single_kind: got ferr want load");
         end
         total++;
         if (ev_q[0].data !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got %h want a5", ev_q[0].data);
         end
         lat = ev_q[0].t - t_start;
         total++;
         if (lat < LAT - 1 || lat > LAT + 1) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT);
         end
      end
      total++;
      if (wide_cnt !== 0 || busy_after !== 0) begin
         bad++;
         $display("FAIL single_pulse: wide %0d busy_after %0d want 0 0",
                  wide_cnt, busy_after);
      end
   endtask

   task automatic test_frame_error();
      int loads;
      clear_log();
      send_frame(8'h3C, 1'b0, 2 * CPB);
      settle();
      loads = 0;
      foreach (ev_q[i]) if (!ev_q[i].err) loads++;
      total++;
      if (ev_q.size() !== 1 || loads !== 0) begin
         bad++;
         $display("FAIL ferr_events: got %0d events %0d loads want 1 0",
                  ev_q.size(), loads);
      end
      total++;
      if (wide_cnt !== 0 || busy_after !== 0 || rx.busy !== 1'b0) begin
         bad++;
         $display("FAIL ferr_pulse: wide %0d after %0d busy %b want 0 0 0",
                  wide_cnt, busy_after, rx.busy);
      end
   endtask

   task automatic test_glitch();
      clear_log();
      hold(1'b0, 1);
      hold(1'b1, 4 * CPB);
      total++;
      if (ev_q.size() !== 0) begin
         bad++;
         $display("FAIL glitch_strobe: got %0d events want 0", ev_q.size());
      end
      total++;
      if (busy_cycles !== CPB / 2) begin
         bad++;
         $display("FAIL glitch_busy: got %0d cycles want %0d",
                  busy_cycles, CPB / 2);
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      send_frame(8'h01, 1'b1, 0);
      send_frame(8'hFE, 1'b1, 0);
      settle();
      total++;
      if (ev_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL b2b_count: got %0d want %0d",
                  ev_q.size(), exp_q.size());
      end
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (ev_q[i].err !== exp_q[i].err || ev_q[i].data !== exp_q[i].data)
         begin
            bad++;
            $display("FAIL b2b_word%0d: got err=%b %h want err=%b %h", i,
                     ev_q[i].err, ev_q[i].data, exp_q[i].err, exp_q[i].data);
         end
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] d;
      logic          s;
      int            g;
      clear_log();
      for (int n = 0; n < 12; n++) begin
         d = NB'($urandom);
         s = ($urandom_range(0, 3) != 0);
         g = s ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
         send_frame(d, s, g);
      end
      settle();
      total++;
      if (ev_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL rand_count: got %0d want %0d",
                  ev_q.size(), exp_q.size());
      end
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (ev_q[i].err !== exp_q[i].err ||
             (!exp_q[i].err && ev_q[i].data !== exp_q[i].data)) begin
            bad++;
            $display("FAIL rand_ev%0d: got err=%b %h want err=%b %h", i,
                     ev_q[i].err, ev_q[i].data, exp_q[i].err, exp_q[i].data);
         end
      end
      total++;
      if (wide_cnt !== 0 || busy_after !== 0) begin
         bad++;
         $display("FAIL rand_pulse: wide %0d after %0d want 0 0",
                  wide_cnt, busy_after);
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      hold(1'b0, CPB);
      for (int i = 0; i < 3; i++) hold(1'b1, CPB);
      @(negedge clk);
      n_rst = 1'b0;
      rx.serial_in = 1'b1;
      @(negedge clk);
      total++;
      if ({rx.load_enable, rx.framing_error, rx.busy} !== 3'b000) begin
         bad++;
         $display("FAIL midrst_strobes: got %b want 000",
                  {rx.load_enable, rx.framing_error, rx.busy});
      end
      total++;
      if (rx.p_data !== '0) begin
         bad++;
         $display("FAIL midrst_pdata: got %h want 00", rx.p_data);
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      hold(1'b1, 2 * CPB);
      send_frame(8'h55, 1'b1, 0);
      settle();
      total++;
      if (ev_q.size() !== 1) begin
         bad++;
         $display("FAIL midrst_count: got %0d want 1", ev_q.size());
      end
      if (ev_q.size() > 0) begin
         total++;
         if (ev_q[0].err !== 1'b0 || ev_q[0].data !== 8'h55) begin
            bad++;
            $display("FAIL midrst_word: got err=%b %h want err=0 55",
                     ev_q[0].err, ev_q[0].data);
         end
      end
   endtask

   task automatic test_break();
      clear_log();
      send_frame(8'h3C, 1'b0, 0);
      hold(1'b0, 10 * CPB);
      total++;
      if (ev_q.size() !== 1 || rx.busy !== 1'b0) begin
         bad++;
         $display("FAIL break_hold: got %0d events busy %b want 1 0",
                  ev_q.size(), rx.busy);
      end
      hold(1'b1, 2 * CPB);
      send_frame(8'h5A, 1'b1, 0);
      settle();
      total++;
      if (ev_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL break_count: got %0d want %0d",
                  ev_q.size(), exp_q.size());
      end
      for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (ev_q[i].err !== exp_q[i].err ||
             (!exp_q[i].err && ev_q[i].data !== exp_q[i].data)) begin
            bad++;
            $display("FAIL break_ev%0d: got err=%b %h want err=%b %h", i,
                     ev_q[i].err, ev_q[i].data, exp_q[i].err, exp_q[i].data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_frame_error();
      test_glitch();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_break();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
